i2c_apb_hub: RTL and testbench

Parametrised APB fan-out hub for a multi-channel I2C subsystem. It sits between the system APB port and NCH independent I2C channel instances, each an APB-slave register block plus core. It decodes the channel index from the address and re-issues each transfer as a registered two-phase APB access to the selected channel. It adds a per-access ready timeout with error response, and it aggregates channel interrupts through edge-latched, maskable pending bits held in local hub registers.

---
 rtl/i2c_apb_hub.sv | 179 +++++++++++++++++
 tb/tb_i2c_apb_hub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_hub.sv
// APB fan-out hub for NCH I2C channels: registered two-phase downstream re-issue,
// access timeout with error response, and edge-latched maskable interrupt aggregation.
module i2c_apb_hub #(
  parameter int NCH       = 4,
  parameter int CH_AW     = 8,
  parameter int TO_CYCLES = 64,
  localparam int CHW      = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                apb_sel,
  input  logic                apb_en,
  input  logic                apb_write,
  input  logic [31:0]         apb_addr,
  input  logic [31:0]         apb_wdata,
  output logic                apb_ready,
  output logic [31:0]         apb_rdata,
  output logic                apb_slverr,
  output logic [NCH-1:0]      ch_sel,
  output logic                ch_en,
  output logic                ch_write,
  output logic [CH_AW-1:0]    ch_addr,
  output logic [31:0]         ch_wdata,
  input  logic [NCH*32-1:0]   ch_rdata,
  input  logic [NCH-1:0]      ch_ready,
  input  logic [NCH-1:0]      ch_irq,
  output logic                hub_irq
);

  localparam int TW = $clog2(TO_CYCLES);
  localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

  typedef enum logic [1:0] {S_IDLE, S_DSETUP, S_DACCESS, S_RESP} state_t;
  state_t r_state, w_state_nxt;

  logic [CH_AW-1:0] r_addr;
  logic [31:0]      r_wdata;
  logic             r_write;
  logic [CHW-1:0]   r_idx;
  logic [TW-1:0]    r_to_cnt;
  logic [31:0]      r_rdata;
  logic             r_slverr;
  logic [NCH-1:0]   r_pend, r_mask, r_prev;
  logic             r_to_flag;
  logic [3:0]       r_to_idx;
  logic             r_hub_irq;

  logic             w_setup, w_local, w_legal, w_lwr;
  logic [CHW-1:0]   w_idx_in;
  logic [31:0]      w_lrd;
  logic [NCH-1:0]   w_pend_clr, w_pend_set, w_onehot;
  logic             w_sel_rdy, w_to_hit;
  logic [31:0]      w_rd_arr [NCH];
  logic             w_unused;

  for (genvar g = 0; g < NCH; g++) begin : g_rd
    assign w_rd_arr[g] = ch_rdata[g*32 +: 32];
  end

  assign w_setup    = (r_state == S_IDLE) && apb_sel && !apb_en;
  assign w_local    = apb_addr[CH_AW+CHW];
  assign w_idx_in   = apb_addr[CH_AW+CHW-1:CH_AW];
  assign w_legal    = {1'b0, w_idx_in} < NCH_L;
  assign w_lwr      = w_setup && w_local && apb_write;
  assign w_pend_set = ch_irq & ~r_prev;
  assign w_pend_clr = (w_lwr && apb_addr[3:2] == 2'd0) ? apb_wdata[NCH-1:0] : '0;
  assign w_sel_rdy  = ch_ready[r_idx];
  assign w_to_hit   = (r_to_cnt == TW'(TO_CYCLES-1));
  assign w_onehot   = {{(NCH-1){1'b0}}, 1'b1} << r_idx;
  assign w_unused   = ^apb_addr[31:CH_AW+CHW+1];

  always_comb begin
    w_lrd = '0;
    case (apb_addr[3:2])
      2'd0: w_lrd = {{(32-NCH){1'b0}}, r_pend};
      2'd1: w_lrd = {{(32-NCH){1'b0}}, r_mask};
      2'd2: w_lrd = {{(32-NCH){1'b0}}, ch_irq};
      2'd3: w_lrd = {r_to_flag, 27'd0, r_to_idx};
      default: w_lrd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ch_sel      = '0;
    ch_en       = 1'b0;
    apb_ready   = 1'b0;
    case (r_state)
      S_IDLE:    if (w_setup) w_state_nxt = (!w_local && w_legal) ? S_DSETUP : S_RESP;
      S_DSETUP: begin
        ch_sel      = w_onehot;
        w_state_nxt = S_DACCESS;
      end
      S_DACCESS: begin
        ch_sel = w_onehot;
        ch_en  = 1'b1;
        if (w_sel_rdy || w_to_hit) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        apb_ready   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_to_cnt  <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_pend    <= '0;
      r_mask    <= '0;
      r_prev    <= '0;
      r_to_flag <= 1'b0;
      r_to_idx  <= '0;
      r_hub_irq <= 1'b0;
    end else begin
      r_prev    <= ch_irq;
      // set has priority over a same-cycle W1C
      r_pend    <= (r_pend & ~w_pend_clr) | w_pend_set;
      r_hub_irq <= |(r_pend & r_mask);
      case (r_state)
        S_IDLE: if (w_setup) begin
          r_addr  <= apb_addr[CH_AW-1:0];
          r_wdata <= apb_wdata;
          r_write <= apb_write;
          r_idx   <= w_idx_in;
          if (w_local) begin
            r_slverr <= 1'b0;
            r_rdata  <= apb_write ? 32'd0 : w_lrd;
            if (apb_write && apb_addr[3:2] == 2'd1) r_mask <= apb_wdata[NCH-1:0];
            if (apb_write && apb_addr[3:2] == 2'd3 && apb_wdata[31]) begin
              r_to_flag <= 1'b0;
              r_to_idx  <= '0;
            end
          end else if (!w_legal) begin
            r_slverr <= 1'b1;
            r_rdata  <= '0;
          end
        end
        S_DSETUP:  r_to_cnt <= '0;
        S_DACCESS: begin
          r_to_cnt <= r_to_cnt + TW'(1);
          if (w_sel_rdy) begin
            r_rdata  <= w_rd_arr[r_idx];
            r_slverr <= 1'b0;
          end else if (w_to_hit) begin
            r_rdata  <= '0;
            r_slverr <= 1'b1;
            // only the first timeout is recorded until software clears the flag
            if (!r_to_flag) begin
              r_to_flag <= 1'b1;
              r_to_idx  <= 4'(r_idx);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_write   = r_write;
  assign ch_addr    = r_addr;
  assign ch_wdata   = r_wdata;
  assign apb_rdata  = r_rdata;
  assign apb_slverr = r_slverr;
  assign hub_irq    = r_hub_irq;

endmodule

// File: tb/tb_i2c_apb_hub.sv
// Directed bench for i2c_apb_hub: u0 (NCH=4, TO=64) carries most traffic,
// u1 (NCH=3) exercises the out-of-range channel index.
module tb_i2c_apb_hub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic apb_sel = 1'b0, apb_en = 1'b0, apb_write = 1'b0, use1 = 1'b0;
  logic [31:0] apb_addr = '0, apb_wdata = '0;

  logic rdy0, err0, chen0, chwr0, hub0;
  logic [31:0] rd0, chwd0;
  logic [3:0] chsel0, chrdy0;
  logic [3:0] chirq0 = '0;
  logic [7:0] chaddr0;
  logic [127:0] chrd0;

  logic rdy1, err1, chen1, chwr1, hub1;
  logic [31:0] rd1, chwd1;
  logic [2:0] chsel1;
  logic [7:0] chaddr1;

  logic m_rdy, m_err;
  logic [31:0] m_rd;

  logic [3:0] rdy_mask = 4'hF, noise = 4'h0;
  int dly = 0, ccnt = 0;
  int ncmp = 0, nerr = 0;

  logic [31:0] x_rd, x_wd_t2;
  logic x_err, x_en_t1, x_en_t2, x_wr_t2, x_en_rdy;
  logic [3:0] x_sel_t1, x_sel_rdy, x_sel_or;
  logic [7:0] x_addr_t2;
  int x_lat;

  always #5 clk = ~clk;

  assign chrd0 = {32'hDEAD_0003, 32'hA5A5_0001, 32'hDEAD_0001, 32'hDEAD_0000};
  always @(posedge clk) ccnt <= chen0 ? ccnt + 1 : 0;
  assign chrdy0 = ((chen0 && ccnt == dly) ? (chsel0 & rdy_mask) : 4'b0) | (noise & ~chsel0);

  assign m_rdy = use1 ? rdy1 : rdy0;
  assign m_rd  = use1 ? rd1  : rd0;
  assign m_err = use1 ? err1 : err0;

  i2c_apb_hub #(.NCH(4), .CH_AW(8), .TO_CYCLES(64)) u0 (
    .clk(clk), .rst(rst), .apb_sel(apb_sel & ~use1), .apb_en(apb_en), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_ready(rdy0), .apb_rdata(rd0),
    .apb_slverr(err0), .ch_sel(chsel0), .ch_en(chen0), .ch_write(chwr0), .ch_addr(chaddr0),
    .ch_wdata(chwd0), .ch_rdata(chrd0), .ch_ready(chrdy0), .ch_irq(chirq0), .hub_irq(hub0));

  i2c_apb_hub #(.NCH(3), .CH_AW(8), .TO_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .apb_sel(apb_sel & use1), .apb_en(apb_en), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_ready(rdy1), .apb_rdata(rd1),
    .apb_slverr(err1), .ch_sel(chsel1), .ch_en(chen1), .ch_write(chwr1), .ch_addr(chaddr1),
    .ch_wdata(chwd1), .ch_rdata(96'd0), .ch_ready(3'd0), .ch_irq(3'd0), .hub_irq(hub1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; x_lat counts cycles from the setup cycle T0.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd);
    apb_addr = a; apb_write = w; apb_wdata = wd; apb_sel = 1'b1; apb_en = 1'b0;
    x_lat = 0; x_rd = 'x; x_err = 1'bx; x_sel_or = '0;
    @(posedge clk); #1;
    apb_en = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      if (k == 1) begin x_sel_t1 = chsel0; x_en_t1 = chen0; end
      if (k == 2) begin x_en_t2 = chen0; x_addr_t2 = chaddr0; x_wr_t2 = chwr0; x_wd_t2 = chwd0; end
      x_sel_or = x_sel_or | chsel0 | {1'b0, chsel1};
      if (m_rdy) begin
        x_lat = k; x_rd = m_rd; x_err = m_err; x_sel_rdy = chsel0; x_en_rdy = chen0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    apb_sel = 1'b0; apb_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rdy0, 0);
    chk("rst_chsel", chsel0, 0);
    chk("rst_chen", chen0, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_slverr", err0, 0);
    chk("rst_chaddr", chaddr0, 0);
    chk("rst_chwdata", chwd0, 0);
    chk("rst_chwrite", chwr0, 0);
    chk("rst_hubirq", hub0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait read of channel 2, with ready noise on the other channels
    noise = 4'b1011;
    xfer(32'h204, 1'b0, 32'h0);
    chk("rd2_lat", x_lat, 3);
    chk("rd2_data", x_rd, 32'hA5A5_0001);
    chk("rd2_err", x_err, 0);
    chk("rd2_sel_t1", x_sel_t1, 4'b0100);
    chk("rd2_en_t1", x_en_t1, 0);
    chk("rd2_en_t2", x_en_t2, 1);
    chk("rd2_addr", x_addr_t2, 8'h04);
    chk("rd2_sel_resp", x_sel_rdy, 0);

    // write to channel 1 with five wait cycles; noise must not finish it early
    dly = 5; noise = 4'b1101;
    xfer(32'h110, 1'b1, 32'h55);
    chk("wr1_lat", x_lat, 8);
    chk("wr1_err", x_err, 0);
    chk("wr1_sel_t1", x_sel_t1, 4'b0010);
    chk("wr1_write", x_wr_t2, 1);
    chk("wr1_wdata", x_wd_t2, 32'h55);
    chk("wr1_addr", x_addr_t2, 8'h10);

    // timeouts: first one is recorded, later ones are not until cleared
    dly = 0; noise = 4'h0; rdy_mask = 4'h0;
    xfer(32'h3F0, 1'b0, 32'h0);
    chk("to3_lat", x_lat, 66);
    chk("to3_err", x_err, 1);
    chk("to3_rdata", x_rd, 0);
    chk("to3_en_resp", x_en_rdy, 0);
    chk("to3_sel_resp", x_sel_rdy, 0);
    xfer(32'h40C, 1'b0, 32'h0);
    chk("tostat_lat", x_lat, 1);
    chk("tostat_a", x_rd, 32'h8000_0003);
    chk("tostat_err", x_err, 0);
    xfer(32'h008, 1'b1, 32'h1234);
    chk("to0_err", x_err, 1);
    xfer(32'h40C, 1'b0, 32'h0);
    chk("tostat_keep", x_rd, 32'h8000_0003);
    xfer(32'h40C, 1'b1, 32'h8000_0000);
    xfer(32'h40C, 1'b0, 32'h0);
    chk("tostat_clr", x_rd[31], 0);
    xfer(32'h100, 1'b0, 32'h0);
    xfer(32'h40C, 1'b0, 32'h0);
    chk("tostat_b", x_rd, 32'h8000_0001);
    rdy_mask = 4'hF;

    // interrupt edge capture, mask and W1C/set collision
    xfer(32'h404, 1'b1, 32'h1);
    xfer(32'h404, 1'b0, 32'h0);
    chk("mask_rd", x_rd, 32'h1);
    chirq0 = 4'b0001;
    @(posedge clk); #1;
    chk("hub_plus1", hub0, 0);
    @(posedge clk); #1;
    chk("hub_plus2", hub0, 1);
    xfer(32'h400, 1'b0, 32'h0);
    chk("pend_set", x_rd, 32'h1);
    xfer(32'h408, 1'b0, 32'h0);
    chk("raw_rd", x_rd, 32'h1);
    xfer(32'h400, 1'b1, 32'h1);
    xfer(32'h400, 1'b0, 32'h0);
    chk("pend_w1c", x_rd, 32'h0);
    chk("hub_cleared", hub0, 0);
    chirq0 = 4'b0000;
    @(posedge clk); #1;
    chirq0 = 4'b0001;
    xfer(32'h400, 1'b1, 32'h1);
    xfer(32'h400, 1'b0, 32'h0);
    chk("pend_set_wins", x_rd, 32'h1);
    chk("hub_set_wins", hub0, 1);
    chirq0 = 4'b0000;

    // out-of-range channel on the NCH=3 instance
    use1 = 1'b1;
    xfer(32'h300, 1'b0, 32'h0);
    chk("ill_lat", x_lat, 1);
    chk("ill_err", x_err, 1);
    chk("ill_rdata", x_rd, 0);
    chk("ill_sel", x_sel_or, 0);
    use1 = 1'b0;

    // reset while the downstream access is stalled
    rdy_mask = 4'h0;
    apb_addr = 32'h300; apb_write = 1'b0; apb_sel = 1'b1; apb_en = 1'b0;
    @(posedge clk); #1;
    apb_en = 1'b1;
    @(posedge clk); #1;
    chk("mid_chen", chen0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_chsel", chsel0, 0);
    chk("mid_rst_chen", chen0, 0);
    chk("mid_rst_ready", rdy0, 0);
    chk("mid_rst_slverr", err0, 0);
    chk("mid_rst_hub", hub0, 0);
    chk("mid_rst_chaddr", chaddr0, 0);
    rst = 1'b0; apb_sel = 1'b0; apb_en = 1'b0;
    @(posedge clk); #1;
    rdy_mask = 4'hF;
    xfer(32'h404, 1'b0, 32'h0);
    chk("post_mask", x_rd, 0);
    xfer(32'h40C, 1'b0, 32'h0);
    chk("post_tostat", x_rd, 0);
    xfer(32'h400, 1'b0, 32'h0);
    chk("post_pend", x_rd, 0);
    xfer(32'h204, 1'b0, 32'h0);
    chk("post_rd_lat", x_lat, 3);
    chk("post_rd_data", x_rd, 32'hA5A5_0001);
    chk("post_rd_err", x_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
